// File: rtl/seg7_to_hex.sv
// seg7_to_hex: samples a multiplexed 7-segment bus, qualifies stable patterns and decodes them
// back to hex/kind/dp through a single-entry valid/ready register. SEG7_SHADOW_EN adds per-digit dedup.
module seg7_to_hex #(
  parameter int STABLE_CYCLES = 4,
  parameter int NDIG          = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NDIG-1:0]         dig_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NDIG)-1:0] out_digit,
  output logic [3:0]              out_hex,
  output logic [1:0]              out_kind,
  output logic                    out_dp,
  output logic                    sel_err,
  output logic                    ovf
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(NDIG);
  localparam logic [CW-1:0] RUN_DONE = CW'(STABLE_CYCLES);
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {SETTLE, HOLD} state_t;
  typedef enum logic [1:0] {
    KIND_HEX     = 2'b00,
    KIND_LAMP    = 2'b01,
    KIND_BLANK   = 2'b10,
    KIND_INVALID = 2'b11
  } kind_t;

  state_t             state;
  logic [NDIG+7:0]    sample;
  logic [CW-1:0]      run_cnt;
  logic               diff;
  logic               qualify;
  logic [7:0]         q_seg;
  logic [NDIG-1:0]    q_sel;
  logic               q_onehot;
  logic [DW-1:0]      q_idx;
  kind_t              dec_kind;
  logic [3:0]         dec_hex;
  logic               dec_dp;
  logic               dup;
  logic               result_ok;
  logic               load;

  // The incoming bus is compared with the held sample, so a run is counted from its first capture.
  assign diff     = {dig_sel, seg_in} != sample;
  assign qualify  = (state == SETTLE) && (run_cnt == RUN_DONE);
  assign q_seg    = sample[7:0];
  assign q_sel    = sample[NDIG+7:8];
  assign q_onehot = $onehot(q_sel);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dec_kind = KIND_INVALID;
    dec_hex  = 4'h0;
    dec_dp   = q_seg[7];
    q_idx    = '0;
    if (q_seg == 8'hFF) begin
      dec_kind = KIND_LAMP;
      dec_dp   = 1'b0;
    end else if (q_seg == 8'h00) begin
      dec_kind = KIND_BLANK;
      dec_dp   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (q_seg[6:0] == SEG_TABLE[i]) begin
          dec_kind = KIND_HEX;
          dec_hex  = 4'(i);
        end
      end
    end
    for (int i = 0; i < NDIG; i++) begin
      if (q_sel[i]) q_idx = DW'(i);
    end
  end

`ifdef SEG7_SHADOW_EN
  logic [NDIG-1:0] shadow_vld;
  logic [6:0]      shadow_data [NDIG];

  assign dup = shadow_vld[q_idx] && (shadow_data[q_idx] == {dec_kind, dec_hex, dec_dp});

  always_ff @(posedge clk) begin
    if (rst)       shadow_vld        <= '0;
    else if (load) shadow_vld[q_idx] <= 1'b1;
  end

  // NOTE: shadow payload has no reset; its valid bit gates every read, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (load) shadow_data[q_idx] <= {dec_kind, dec_hex, dec_dp};
  end
`else
  assign dup = 1'b0;
`endif

  assign result_ok = qualify && q_onehot && !dup;
  assign load      = result_ok && (!out_valid || out_ready);

  // NOTE: all state here is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SETTLE;
      sample    <= '0;
      run_cnt   <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_hex   <= 4'h0;
      out_kind  <= KIND_HEX;
      out_dp    <= 1'b0;
      sel_err   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sample <= {dig_sel, seg_in};
      if (diff)                      run_cnt <= CW'(1);
      else if (run_cnt != RUN_DONE)  run_cnt <= run_cnt + 1'b1;

      // A change on the qualifying edge already starts the next run, so stay in SETTLE for it.
      case (state)
        SETTLE: if (qualify) state <= diff ? SETTLE : HOLD;
        HOLD:   if (diff)    state <= SETTLE;
        default:             state <= SETTLE;
      endcase

      if (qualify && !q_onehot)                   sel_err <= 1'b1;
      if (result_ok && out_valid && !out_ready)   ovf     <= 1'b1;

      if (load) begin
        out_valid <= 1'b1;
        out_digit <= q_idx;
        out_hex   <= dec_hex;
        out_kind  <= dec_kind;
        out_dp    <= dec_dp;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_to_hex.sv
// tb_seg7_to_hex: directed scenarios plus randomized runs, each cycle compared against a
// run-history reference model of the segment decoder.
module tb_seg7_to_hex;

  localparam int S    = 4;
  localparam int NDIG = 4;

  logic            clk;
  logic            rst;
  logic [7:0]      seg_in;
  logic [NDIG-1:0] dig_sel;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_digit;
  logic [3:0]      out_hex;
  logic [1:0]      out_kind;
  logic            out_dp;
  logic            sel_err;
  logic            ovf;

  seg7_to_hex #(.STABLE_CYCLES(S), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_hex   (out_hex),
    .out_kind  (out_kind),
    .out_dp    (out_dp),
    .sel_err   (sel_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt;
  logic [1:0] seen_kinds [$];

  // Reference model state
  logic [NDIG+7:0] hist [$];
  logic            m_valid, m_dp, m_sel_err, m_ovf;
  logic [1:0]      m_digit, m_kind;
  logic [3:0]      m_hex;
  logic            m_sh_vld  [NDIG];
  logic [6:0]      m_sh_data [NDIG];
  int              hex_of [logic [6:0]];
  logic [7:0]      seg_pool [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {kind, hex, dp} straight from the pattern rules.
  function automatic logic [6:0] ref_decode(input logic [7:0] s);
    if (s == 8'hFF) return {2'b01, 4'h0, 1'b0};
    if (s == 8'h00) return {2'b10, 4'h0, 1'b0};
    if (hex_of.exists(s[6:0])) return {2'b00, 4'(hex_of[s[6:0]]), s[7]};
    return {2'b11, 4'h0, s[7]};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_valid = 0; m_digit = 0; m_hex = 0; m_kind = 0; m_dp = 0; m_sel_err = 0; m_ovf = 0;
    for (int i = 0; i < NDIG; i++) begin
      m_sh_vld[i]  = 0;
      m_sh_data[i] = '0;
    end
  endtask

  // A run qualifies on the edge after its S-th capture; runs are bounded by value changes or reset.
  task automatic model_edge(input logic [NDIG-1:0] d, input logic [7:0] s, input logic rdy, input logic r);
    int n;
    bit qual, loaded, dup;
    logic [NDIG+7:0] v;
    logic [6:0] res;
    int idx;
    if (r) begin
      model_reset();
      return;
    end
    n = hist.size();
    qual = 0;
    loaded = 0;
    if (n >= S) begin
      qual = 1;
      for (int i = n - S; i < n; i++) if (hist[i] != hist[n-1]) qual = 0;
      if (n > S && hist[n-S-1] == hist[n-1]) qual = 0;
    end
    if (qual) begin
      v = hist[n-1];
      if ($countones(v[NDIG+7:8]) != 1) begin
        m_sel_err = 1;
      end else begin
        idx = $clog2(v[NDIG+7:8]);
        res = ref_decode(v[7:0]);
        dup = 0;
`ifdef SEG7_SHADOW_EN
        dup = m_sh_vld[idx] && (m_sh_data[idx] == res);
`endif
        if (!dup) begin
          if (!m_valid || rdy) begin
            m_valid = 1;
            m_digit = 2'(idx);
            {m_kind, m_hex, m_dp} = res;
            m_sh_vld[idx]  = 1;
            m_sh_data[idx] = res;
            loaded = 1;
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
    if (!loaded && m_valid && rdy) m_valid = 0;
    hist.push_back({d, s});
    if (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  task automatic step(input logic [NDIG-1:0] d, input logic [7:0] s, input logic rdy, input logic r);
    dig_sel   = d;
    seg_in    = s;
    out_ready = rdy;
    rst       = r;
    @(posedge clk);
    model_edge(d, s, rdy, r);
    #1;
    check("outputs", {20'h0, out_valid, out_digit, out_hex, out_kind, out_dp, sel_err, ovf},
                     {20'h0, m_valid, m_digit, m_hex, m_kind, m_dp, m_sel_err, m_ovf});
    if (out_valid) begin
      valid_cnt++;
      seen_kinds.push_back(out_kind);
    end
  endtask

  task automatic do_reset();
    step('0, 8'h00, 1'b1, 1'b1);
    step('0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] kseq [4];
    logic [7:0] s_rand;
    logic [NDIG-1:0] d_rand;
    int hold;

    seg_pool = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    for (int i = 0; i < 16; i++) hex_of[seg_pool[i][6:0]] = i;
    model_reset();
    valid_cnt = 0;

    // Reset state
    do_reset();
    check("reset_outputs", {out_valid, out_digit, out_hex, out_kind, out_dp, sel_err, ovf}, 0);

    // Single digit, latency S+1, one report per held run
    repeat (S + 1) step(4'b0010, 8'h5B, 1'b1, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_digit", out_digit, 1);
    check("t1_hex",   out_hex,   2);
    check("t1_kind",  out_kind,  0);
    check("t1_dp",    out_dp,    0);
    valid_cnt = 0;
    repeat (8) step(4'b0010, 8'h5B, 1'b1, 1'b0);
    check("t1_no_repeat", valid_cnt, 0);

    // Pattern classes in order
    do_reset();
    seen_kinds.delete();
    kseq = '{8'hFF, 8'h00, 8'hE6, 8'h49};
    for (int k = 0; k < 4; k++) repeat (6) step(4'b0001, kseq[k], 1'b1, 1'b0);
    check("t2_count", seen_kinds.size(), 4);
    if (seen_kinds.size() == 4) begin
      check("t2_kind0", seen_kinds[0], 2'b01);
      check("t2_kind1", seen_kinds[1], 2'b10);
      check("t2_kind2", seen_kinds[2], 2'b00);
      check("t2_kind3", seen_kinds[3], 2'b11);
    end

    // Too-short runs never report; non-one-hot select flags sel_err
    do_reset();
    valid_cnt = 0;
    for (int k = 0; k < 6; k++) repeat (3) step(4'b0001, (k % 2 == 0) ? 8'h06 : 8'h5B, 1'b1, 1'b0);
    check("t3_short_runs", valid_cnt, 0);
    repeat (6) step(4'b0110, 8'h06, 1'b1, 1'b0);
    check("t3_sel_err", sel_err, 1);
    check("t3_no_emit", valid_cnt, 0);

    // Overflow: hold first, drop second, load third on the ready edge
    do_reset();
    check("t4_ovf_clear", ovf, 0);
    repeat (S) step(4'b1000, 8'h07, 1'b0, 1'b0);
    repeat (S) step(4'b0100, 8'h77, 1'b0, 1'b0);
    check("t4_first_held", {out_valid, out_digit, out_hex}, {1'b1, 2'd3, 4'h7});
    repeat (S) step(4'b0010, 8'h4F, 1'b0, 1'b0);
    check("t4_still_first", {out_digit, out_hex}, {2'd3, 4'h7});
    check("t4_ovf_set", ovf, 1);
    step(4'b0010, 8'h4F, 1'b1, 1'b0);
    check("t4_third", {out_valid, out_digit, out_hex}, {1'b1, 2'd1, 4'h3});
    check("t4_ovf_sticky", ovf, 1);
    step(4'b0010, 8'h4F, 1'b1, 1'b0);
    check("t4_drained", out_valid, 0);

    // Shadow suppression of a repeated digit value
    do_reset();
    valid_cnt = 0;
    repeat (6) step(4'b0001, 8'h3F, 1'b1, 1'b0);
    repeat (6) step(4'b0010, 8'h06, 1'b1, 1'b0);
    repeat (6) step(4'b0001, 8'h3F, 1'b1, 1'b0);
`ifdef SEG7_SHADOW_EN
    check("t5_reports", valid_cnt, 2);
`else
    check("t5_reports", valid_cnt, 3);
`endif

    // Reset mid-run restarts qualification
    do_reset();
    repeat (2) step(4'b0001, 8'h07, 1'b1, 1'b0);
    step(4'b0001, 8'h07, 1'b1, 1'b1);
    check("t6_in_reset", {out_valid, out_digit, out_hex, out_kind, out_dp, sel_err, ovf}, 0);
    valid_cnt = 0;
    repeat (S) step(4'b0001, 8'h07, 1'b1, 1'b0);
    check("t6_no_early", valid_cnt, 0);
    step(4'b0001, 8'h07, 1'b1, 1'b0);
    check("t6_report", {out_valid, out_hex}, {1'b1, 4'h7});

    // Randomized runs against the model
    do_reset();
    for (int run = 0; run < 900; run++) begin
      if ($urandom_range(0, 99) < 85) d_rand = NDIG'(1) << $urandom_range(0, NDIG - 1);
      else                            d_rand = NDIG'($urandom);
      case ($urandom_range(0, 9))
        0:       s_rand = 8'hFF;
        1:       s_rand = 8'h00;
        2:       s_rand = 8'($urandom);
        default: s_rand = seg_pool[$urandom_range(0, 15)] | ($urandom_range(0, 3) == 0 ? 8'h80 : 8'h00);
      endcase
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++)
        step(d_rand, s_rand, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
